// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, LSB first, 8N1 by default (DATA_BITS 5..8).
// Latency: rx_valid/frame_err/parity_err pulse one clk after the baud tick that samples the stop bit.
// Backpressure: none; each word is a 1-clk pulse on rx_valid, and rx_data holds the last good word.
// Optional parity stage: define UART_RX_PARITY_EN (PARITY_ODD selects odd parity).
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_clk,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [3:0]           scnt_q, scnt_d;
  logic [2:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 rxd_m_q, rxd_s_q;
  logic                 baud_d_q;
  logic                 tick;

  // One clk pulse per rising edge of the oversampling clock.
  assign tick = baud_clk & ~baud_d_q;

  // Synchronise rxd (idle high) and keep one cycle of baud_clk history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_m_q  <= 1'b1;
      rxd_s_q  <= 1'b1;
      baud_d_q <= 1'b0;
    end else begin
      rxd_m_q  <= rxd;
      rxd_s_q  <= rxd_m_q;
      baud_d_q <= baud_clk;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic pbad_q, pbad_d;
  logic perr_q, perr_d;
`endif

  // Frame FSM: sample mid-bit at scnt == 15, leave at stop-bit mid for back-to-back margin.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s_q) begin
            state_d = START;
            scnt_d  = 4'd0;
          end
        end
        START: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd7) begin
            if (rxd_s_q) begin
              // Line went back high before the start-bit middle: glitch.
              state_d = IDLE;
            end else begin
              scnt_d  = 4'd0;
              bcnt_d  = 3'd0;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            if (DATA_BITS > 1) sh_d = {rxd_s_q, sh_q[DATA_BITS-1:1]};
            else               sh_d = rxd_s_q;
            if (bcnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            // Mismatch when received bit differs from XOR(data) (inverted for odd).
            pbad_d  = rxd_s_q ^ (^sh_q) ^ PARITY_ODD;
            state_d = STOP;
          end
        end
`endif
        STOP: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            if (rxd_s_q) begin
              data_d  = sh_q;
              valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_d  = pbad_q;
`endif
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end
        end
        BREAK: begin
          // Wait out a held-low line so it cannot be mistaken for new frames.
          if (rxd_s_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters, shift register and output pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      scnt_q  <= 4'd0;
      bcnt_q  <= 3'd0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity verdict held from the parity bit until the stop bit resolves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pbad_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      pbad_q <= pbad_d;
      perr_q <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: scoreboard of expected output pulses pushed per transmitted frame.
// Clock 10 ns, baud_clk period 16 clk, one bit = 256 clk.
// Monitor pops one expectation per output pulse and checks pulse width.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT = 2560;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_clk = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic       prev_pulse = 1'b0;

  uart_rx #(.DATA_BITS(8), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  initial forever #80 baud_clk = ~baud_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one frame and record the pulse it must produce.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    exp_t e;
    e.d  = stop_bit ? d : last_good;
    e.fe = ~stop_bit;
    e.pe = stop_bit & par_flip;
    if (stop_bit) last_good = d;
    exp_q.push_back(e);
    rxd = 1'b0;
    #BIT;
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      #BIT;
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ 1'b0 ^ par_flip;
    #BIT;
`endif
    rxd = stop_bit;
    #BIT;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (prev_pulse) begin
      check("pulse_width", {29'd0, rx_valid, frame_err, parity_err}, 32'd0);
      prev_pulse = 1'b0;
    end else if (rst_n && (rx_valid || frame_err || parity_err)) begin
      prev_pulse = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, rx_valid, frame_err, parity_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_valid", {31'd0, rx_valid}, {31'd0, ~e.fe});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        check("rx_data", {24'd0, rx_data}, {24'd0, e.d});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (4) @(negedge clk);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #BIT;

    // Plain frame.
    send_frame(8'h55, 1'b1, 1'b0);
    #BIT;
    check("busy_after_55", {31'd0, busy}, 32'd0);

    // Glitch of 3 ticks on the line.
    rxd = 1'b0;
    #480;
    rxd = 1'b1;
    #(16 * 160);
    check("busy_after_glitch", {31'd0, busy}, 32'd0);
    #BIT;

    // Stop bit low, line held low, then recovery.
    send_frame(8'hA3, 1'b0, 1'b0);
    #(40 * 160);
    check("busy_in_break", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    #BIT;
    check("rx_data_after_break", {24'd0, rx_data}, 32'h55);
    send_frame(8'h3C, 1'b1, 1'b0);
    rxd = 1'b1;
    #BIT;

    // Back-to-back frames with a single stop bit.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    rxd = 1'b1;
    #BIT;

    // Reset in the middle of data bit 4 of 0x5A; frame abandoned.
    begin
      logic [7:0] p;
      p = 8'h5A;
      rxd = 1'b0;
      #BIT;
      for (int i = 0; i < 4; i++) begin
        rxd = p[i];
        #BIT;
      end
      rxd = p[4];
      #(BIT / 2);
      @(negedge clk);
      check("busy_mid_frame", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      last_good = 8'h00;
      check("rx_data_after_reset", {24'd0, rx_data}, 32'd0);
      check("busy_after_reset", {31'd0, busy}, 32'd0);
      rxd = 1'b1;
      #(3 * BIT);
      check("rx_data_idle_after_reset", {24'd0, rx_data}, 32'd0);
    end
    send_frame(8'h96, 1'b1, 1'b0);
    rxd = 1'b1;
    #BIT;

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has XOR 1; wrong parity bit 0 then correct bit 1.
    send_frame(8'h07, 1'b1, 1'b1);
    rxd = 1'b1;
    #BIT;
    send_frame(8'h07, 1'b1, 1'b0);
    rxd = 1'b1;
    #BIT;
`endif

    check("final_rx_data", {24'd0, rx_data}, {24'd0, last_good});
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampling UART receiver. Directly downstream of the baud-rate generator: consumes its baud_clk (a square wave at 16 x baudrate) and the serial rxd line.
- Frame format: 8N1 by default, LSB first.
- Delivers each received word with a 1-clk valid pulse and flags framing errors.
- Sits between the board RX pin and the command-parser FIFO.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- baud_clk  input  1  16 x baudrate square wave from the baud generator; asynchronous content treated as level.
- rxd  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  last good received word.
- rx_valid  output  1  1-clk pulse: rx_data updated.
- frame_err  output  1  1-clk pulse: stop bit sampled low.
- parity_err  output  1  1-clk pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low at posedge clk) is synchronous and active-low. It forces:
  - state = IDLE; rx_data = 0; rx_valid = frame_err = parity_err = busy = 0.
  - sample counter = 0, bit counter = 0.
  - rxd synchroniser FFs = 1; baud_clk history FF = 0.
- Reset mid-frame aborts the frame with no output pulse.
- Input conditioning:
  - rxd passes through a 2-FF synchroniser, giving rxd_s.
  - baud_clk is registered once. tick = baud_clk & ~baud_clk_d, i.e. a 1-clk pulse per baud_clk rising edge.
  - All state and counter activity advances only on tick.
- Counters:
  - scnt: 4 bits, counts ticks, wraps 15 -> 0.
  - bcnt: 3 bits, counts data bits.
- States:
  - IDLE: on tick with rxd_s == 0, go to START with scnt = 0.
  - START: on tick, scnt++. At the tick where scnt == 7 (mid start bit):
    - rxd_s == 1: false start (glitch), go to IDLE.
    - otherwise: scnt = 0, bcnt = 0, go to DATA.
  - DATA: on tick, scnt++. At scnt == 15 (bit mid), shift rxd_s into the MSB of the shift register (LSB-first reception).
    - bcnt == DATA_BITS-1: go to STOP (or PARITY with the macro).
    - otherwise: bcnt++.
  - STOP: at scnt == 15:
    - rxd_s == 1: rx_data = shift register, pulse rx_valid, go to IDLE.
    - rxd_s == 0: pulse frame_err, rx_data unchanged, go to BREAK.
  - BREAK: remain until rxd_s == 1 on a tick, then go to IDLE. A held-low line therefore never produces spurious frames.
- Latency and timing:
  - rx_valid / frame_err assert one clk after the tick that samples the stop bit.
  - Leaving STOP at the stop-bit mid gives half a bit of margin, so back-to-back frames with exactly one stop bit are received without loss.
- Width rule: for DATA_BITS < 8, the shift register is DATA_BITS wide, so rx_data holds the word right-aligned.
- Output pulses are exactly 1 clk wide and never coincide with another frame's pulse.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, with the same scnt == 15 sampling.
  - The expected parity bit is XOR(data) for even, or ~XOR(data) when PARITY_ODD = 1.
  - On mismatch, parity_err pulses in the same clk as rx_valid. Data is still delivered.
  - A stop-bit error still gives frame_err only.
- Undefined:
  - No PARITY state; frame is start + DATA_BITS + stop.
  - parity_err is constant 0.

Test Plan:
- Bench drives baud_clk with period 16 clk, so 1 bit = 256 clk.
- Frame 0x55, 8N1, rxd idle high before and after -> exactly one rx_valid pulse, rx_data = 0x55, frame_err = 0, busy low afterwards.
- rxd low for 3 ticks (48 clk) then high -> no rx_valid, no frame_err, state returns to IDLE, busy low within 8 ticks.
- Frame 0xA3 with stop bit low, then line held low for 40 ticks, then 0x3C sent -> one frame_err pulse, rx_data stays at previous value, no spurious frames; then rx_valid with rx_data = 0x3C.
- Back-to-back 0x00, 0xFF, 0x81 with a single stop bit and no idle gap -> three rx_valid pulses, data in order.
- rst_n low for 1 clk in the middle of data bit 4 of 0x5A, then a full 0x96 frame -> no output for 0x5A, rx_data = 0 after reset, then rx_data = 0x96.
- With UART_RX_PARITY_EN and PARITY_ODD = 0:
  - 0x07 sent with parity bit 0 -> rx_valid with parity_err = 1, rx_data = 0x07.
  - 0x07 sent with parity bit 1 -> parity_err = 0.
